id_stage: RTL and testbench

Instruction Decode stage of the core_lapido pipeline, directly downstream of the Instruction Fetch stage.
- Contains the IF/ID latch, a 32x32 register file with a WB write port, a hazard unit and the ID/EX latch.
- Resolves jumps and BEQ/BNE in ID, returning is_jump/jump_addr/branch_taken/branch_addr to Instruction Fetch.
- Drives a stall back to Instruction Fetch on load-use and branch-operand hazards.

---
 rtl/id_stage_pkg.sv | 61 ++++++
 rtl/id_stage_if.sv | 40 ++++
 rtl/id_stage_reg_file.sv | 34 +++
 rtl/id_stage.sv | 107 ++++++++++
 tb/tb_id_stage.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pkg.sv
// Shared core_lapido ID-stage definitions: the lapido_defs macros (`PC_WIDTH, `NOP_INSTRUCTION),
// opcodes, field positions and decode helpers. Optional feature macro: LAPIDO_REG_BYPASS_EN.
`ifndef LAPIDO_DEFS_V
`define LAPIDO_DEFS_V
`define PC_WIDTH 16
`define NOP_INSTRUCTION 32'h0000_0000
`endif

package id_stage_pkg;
  localparam int PC_WIDTH = `PC_WIDTH;
  localparam int NREG = 32;
  localparam logic [31:0] NOP_INSTRUCTION = `NOP_INSTRUCTION;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
  } instr_t;

  typedef struct packed {
    logic                valid;
    logic [5:0]          opcode;
    logic [31:0]         rs_data;
    logic [31:0]         rt_data;
    logic [31:0]         imm;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [PC_WIDTH-1:0] pc;
  } ex_t;

  function automatic instr_t decode(logic [31:0] w);
    decode.opcode = w[OPC_LSB +: 6];
    decode.rs     = w[RS_LSB +: 5];
    decode.rt     = w[RT_LSB +: 5];
    decode.rd     = w[RD_LSB +: 5];
    decode.imm    = w[15:0];
  endfunction

  // ALU-immediate opcodes occupy 6'h08..6'h0F.
  function automatic logic writes_reg(logic [5:0] op);
    return (op == OP_RTYPE) || (op[5:3] == 3'b001) || (op == OP_LW);
  endfunction

  function automatic logic [4:0] dest_reg(logic [5:0] op, logic [4:0] rt, logic [4:0] rd);
    return (op == OP_RTYPE) ? rd : rt;
  endfunction
endpackage

// File: rtl/id_stage_if.sv
// Bus bundle between the ID stage and its IF, EX, MEM and WB neighbours.
interface id_stage_if;
  import id_stage_pkg::*;

  // Flow control: IF presents instruction/next_pc every cycle and holds them while
  // stall=1; ex_valid=1 marks a real instruction in ID/EX, ex_valid=0 a bubble.
  logic [31:0]         instruction;
  logic [PC_WIDTH-1:0] next_pc;
  logic                mem_we;
  logic [4:0]          mem_dest;
  logic                wb_we;
  logic [4:0]          wb_addr;
  logic [31:0]         wb_data;
  logic                stall;
  logic                is_jump;
  logic [PC_WIDTH-1:0] jump_addr;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_addr;
  logic                ex_valid;
  logic [5:0]          ex_opcode;
  logic [31:0]         ex_rs_data;
  logic [31:0]         ex_rt_data;
  logic [31:0]         ex_imm;
  logic [4:0]          ex_rs;
  logic [4:0]          ex_rt;
  logic [4:0]          ex_rd;
  logic [PC_WIDTH-1:0] ex_pc;

  modport master (
    output instruction, next_pc, mem_we, mem_dest, wb_we, wb_addr, wb_data,
    input  stall, is_jump, jump_addr, branch_taken, branch_addr,
    input  ex_valid, ex_opcode, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_pc
  );

  modport slave (
    input  instruction, next_pc, mem_we, mem_dest, wb_we, wb_addr, wb_data,
    output stall, is_jump, jump_addr, branch_taken, branch_addr,
    output ex_valid, ex_opcode, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_pc
  );
endinterface

// File: rtl/id_stage_reg_file.sv
// 32x32 register file, two combinational read ports, one write port, r0 reads 0.
// With LAPIDO_REG_BYPASS_EN defined, a same-cycle write is forwarded to the readers.
module reg_file
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra_addr,
  output logic [31:0] ra_data,
  input  logic [4:0]  rb_addr,
  output logic [31:0] rb_data,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    ra_data = (ra_addr == 5'd0) ? 32'd0 : regs[ra_addr];
    rb_data = (rb_addr == 5'd0) ? 32'd0 : regs[rb_addr];
`ifdef LAPIDO_REG_BYPASS_EN
    if (we && (wa != 5'd0) && (wa == ra_addr)) ra_data = wd;
    if (we && (wa != 5'd0) && (wa == rb_addr)) rb_data = wd;
`endif
  end
endmodule

// File: rtl/id_stage.sv
// core_lapido Instruction Decode: IF/ID latch, register file, hazard/stall unit, J/BEQ/BNE
// resolution and ID/EX latch. LAPIDO_REG_BYPASS_EN selects WB write-through vs. a WB stall.
module id_stage
  import id_stage_pkg::*;
(
  input logic      clk,
  input logic      rst,
  id_stage_if.slave bus
);
  logic [31:0]         ifid_instr;
  logic [PC_WIDTH-1:0] ifid_pc;
  instr_t              id;
  logic [31:0]         rs_data, rt_data, imm_ext;
  ex_t                 ex_q;

  logic id_branch, ex_writes, stall;
  logic [4:0] ex_dest;
  logic load_use, ex_branch_haz, mem_branch_haz, wb_haz, cond_true;

  assign id      = decode(ifid_instr);
  assign imm_ext = {{16{id.imm[15]}}, id.imm};

  reg_file u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (id.rs),
    .ra_data (rs_data),
    .rb_addr (id.rt),
    .rb_data (rt_data),
    .we      (bus.wb_we),
    .wa      (bus.wb_addr),
    .wd      (bus.wb_data)
  );

  always_comb begin
    id_branch = (id.opcode == OP_BEQ) || (id.opcode == OP_BNE);
    ex_dest   = dest_reg(ex_q.opcode, ex_q.rt, ex_q.rd);
    ex_writes = ex_q.valid && writes_reg(ex_q.opcode) && (ex_dest != 5'd0);

    load_use = ex_q.valid && (ex_q.opcode == OP_LW) && (ex_q.rt != 5'd0) &&
               ((ex_q.rt == id.rs) || (ex_q.rt == id.rt));
    ex_branch_haz  = id_branch && ex_writes && ((ex_dest == id.rs) || (ex_dest == id.rt));
    mem_branch_haz = id_branch && bus.mem_we && (bus.mem_dest != 5'd0) &&
                     ((bus.mem_dest == id.rs) || (bus.mem_dest == id.rt));
`ifdef LAPIDO_REG_BYPASS_EN
    wb_haz = 1'b0;
`else
    // Without write-through, wait one cycle for the WB write to land.
    wb_haz = bus.wb_we && (bus.wb_addr != 5'd0) &&
             ((bus.wb_addr == id.rs) || (bus.wb_addr == id.rt));
`endif
    stall = load_use || ex_branch_haz || mem_branch_haz || wb_haz;

    cond_true = ((id.opcode == OP_BEQ) && (rs_data == rt_data)) ||
                ((id.opcode == OP_BNE) && (rs_data != rt_data));
  end

  assign bus.stall        = stall;
  assign bus.is_jump      = (id.opcode == OP_J) && !stall;
  assign bus.jump_addr    = ifid_instr[PC_WIDTH-1:0];
  assign bus.branch_taken = cond_true && !stall;
  assign bus.branch_addr  = ifid_pc + imm_ext[PC_WIDTH-1:0];

  // Stall holds IF/ID and takes priority over the wrong-path flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instr <= NOP_INSTRUCTION;
      ifid_pc    <= '0;
    end else if (!stall) begin
      if (bus.is_jump || bus.branch_taken) begin
        ifid_instr <= NOP_INSTRUCTION;
        ifid_pc    <= '0;
      end else begin
        ifid_instr <= bus.instruction;
        ifid_pc    <= bus.next_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (stall) begin
      ex_q <= '0;
    end else begin
      ex_q.valid   <= (ifid_instr != NOP_INSTRUCTION);
      ex_q.opcode  <= id.opcode;
      ex_q.rs_data <= rs_data;
      ex_q.rt_data <= rt_data;
      ex_q.imm     <= imm_ext;
      ex_q.rs      <= id.rs;
      ex_q.rt      <= id.rt;
      ex_q.rd      <= id.rd;
      ex_q.pc      <= ifid_pc;
    end
  end

  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_opcode  = ex_q.opcode;
  assign bus.ex_rs_data = ex_q.rs_data;
  assign bus.ex_rt_data = ex_q.rt_data;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_rs      = ex_q.rs;
  assign bus.ex_rt      = ex_q.rt;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_pc      = ex_q.pc;
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: vector table of hazard-free instructions plus
// hand-written hazard, branch, jump, bypass and reset sequences.
module tb_id_stage;
  import id_stage_pkg::*;

  localparam int W = 6 + 32 + 32 + 32 + PC_WIDTH;

  logic clk;
  logic rst;
  id_stage_if bus();

  id_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  reg_model [32];

  typedef struct {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
    logic [5:0]          exp_op;
    logic [31:0]         exp_rs;
    logic [31:0]         exp_rt;
    logic [31:0]         exp_imm;
  } vec_t;
  vec_t vecs [6];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pack(logic [5:0] op, logic [31:0] rs_d, logic [31:0] rt_d,
                                        logic [31:0] imm, logic [PC_WIDTH-1:0] pc);
    return {op, rs_d, rt_d, imm, pc};
  endfunction

  function automatic logic [31:0] r_type(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {6'h00, rs, rt, rd, 11'h000};
  endfunction

  function automatic logic [31:0] i_type(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.instruction = NOP_INSTRUCTION;
    bus.next_pc     = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [31:0] instr, input logic [PC_WIDTH-1:0] pc);
    bus.instruction = instr;
    bus.next_pc     = pc;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_we   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    tick();
    bus.wb_we = 1'b0;
    if (addr != 5'd0) reg_model[addr] = data;
  endtask

  // Push the expected ID/EX contents of an instruction that must reach EX.
  task automatic expect_ex(input logic [31:0] instr, input logic [PC_WIDTH-1:0] pc,
                           input logic [31:0] rs_d, input logic [31:0] rt_d);
    exp_q.push_back(pack(instr[31:26], rs_d, rt_d, {{16{instr[15]}}, instr[15:0]}, pc));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    if (!rst && bus.ex_valid) begin
      act = pack(bus.ex_opcode, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_pc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ex_unexpected: got 0x%0h with nothing expected at %0t", act, $time);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL ex_out: got 0x%0h expected 0x%0h at %0t", act, exp, $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] t;
    rst = 1'b1;
    bus.instruction = NOP_INSTRUCTION;
    bus.next_pc  = '0;
    bus.mem_we   = 1'b0;
    bus.mem_dest = '0;
    bus.wb_we    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    for (int i = 0; i < 32; i++) reg_model[i] = '0;
    tick();
    tick();
    check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_is_jump", {31'd0, bus.is_jump}, 32'd0);
    check("rst_branch_taken", {31'd0, bus.branch_taken}, 32'd0);
    rst = 1'b0;
    tick();

    // Preload registers.
    wb_write(5'd1, 32'h1111_1111);
    wb_write(5'd2, 32'h2222_2222);
    wb_write(5'd3, 32'h3333_3333);
    wb_write(5'd4, 32'h4444_4444);
    wb_write(5'd6, 32'h6666_6666);
    wb_write(5'd7, 32'h7777_7777);
    idle(2);

    // Hazard-free vector table.
    vecs[0] = '{r_type(5'd1, 5'd2, 5'd3), 16'h01, 6'h00, 32'h1111_1111, 32'h2222_2222, 32'h0000_1800};
    vecs[1] = '{i_type(6'h08, 5'd4, 5'd9, 16'hFFFF), 16'h02, 6'h08, 32'h4444_4444, 32'h0, 32'hFFFF_FFFF};
    vecs[2] = '{i_type(6'h0C, 5'd0, 5'd5, 16'h8000), 16'h03, 6'h0C, 32'h0, 32'h0, 32'hFFFF_8000};
    vecs[3] = '{i_type(6'h23, 5'd6, 5'd10, 16'h0004), 16'h04, 6'h23, 32'h6666_6666, 32'h0, 32'h0000_0004};
    vecs[4] = '{r_type(5'd7, 5'd2, 5'd11), 16'h05, 6'h00, 32'h7777_7777, 32'h2222_2222, 32'h0000_5800};
    vecs[5] = '{i_type(6'h0F, 5'd3, 5'd12, 16'h7FFF), 16'h06, 6'h0F, 32'h3333_3333, 32'h0, 32'h0000_7FFF};
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].instr, vecs[i].pc);
      exp_q.push_back(pack(vecs[i].exp_op, vecs[i].exp_rs, vecs[i].exp_rt, vecs[i].exp_imm, vecs[i].pc));
      tick();
      check("vec_no_stall", {31'd0, bus.stall}, 32'd0);
    end
    idle(3);

    // WB write then read, two-posedge latency.
    wb_write(5'd5, 32'h0000_1234);
    t = r_type(5'd5, 5'd0, 5'd6);
    drive(t, 16'h20);
    expect_ex(t, 16'h20, 32'h0000_1234, 32'h0);
    tick();
    idle(1);
    check("wb_read_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("wb_read_rs_data", bus.ex_rs_data, 32'h0000_1234);
    idle(2);

    // Same-cycle WB write and read of r7.
    t = r_type(5'd7, 5'd0, 5'd8);
    drive(t, 16'h21);
    expect_ex(t, 16'h21, 32'h0000_BEEF, 32'h0);
    tick();
    drive(NOP_INSTRUCTION, '0);
    bus.wb_we   = 1'b1;
    bus.wb_addr = 5'd7;
    bus.wb_data = 32'h0000_BEEF;
    #1;
`ifdef LAPIDO_REG_BYPASS_EN
    check("same_cycle_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    bus.wb_we = 1'b0;
    reg_model[7] = 32'h0000_BEEF;
    check("same_cycle_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
`else
    check("same_cycle_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    bus.wb_we = 1'b0;
    reg_model[7] = 32'h0000_BEEF;
    #1;
    check("same_cycle_bubble", {31'd0, bus.ex_valid}, 32'd0);
    check("same_cycle_stall_clear", {31'd0, bus.stall}, 32'd0);
    tick();
    check("same_cycle_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
`endif
    idle(2);

    // Load-use: LW r3 in EX, ADD reading r3 in ID.
    t = i_type(6'h23, 5'd0, 5'd3, 16'h0000);
    drive(t, 16'h30);
    expect_ex(t, 16'h30, 32'h0, reg_model[3]);
    tick();
    t = r_type(5'd3, 5'd1, 5'd4);
    drive(t, 16'h31);
    expect_ex(t, 16'h31, reg_model[3], reg_model[1]);
    tick();
    check("load_use_stall", {31'd0, bus.stall}, 32'd1);
    drive(NOP_INSTRUCTION, '0);
    tick();
    check("load_use_bubble", {31'd0, bus.ex_valid}, 32'd0);
    check("load_use_stall_clear", {31'd0, bus.stall}, 32'd0);
    tick();
    check("load_use_add_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("load_use_add_op", {26'd0, bus.ex_opcode}, 32'h0);
    idle(2);

    // BEQ r1,r2 taken, imm -4 at next_pc 0x10.
    wb_write(5'd2, reg_model[1]);
    idle(2);
    t = i_type(6'h04, 5'd1, 5'd2, 16'hFFFC);
    drive(t, 16'h10);
    expect_ex(t, 16'h10, reg_model[1], reg_model[2]);
    tick();
    check("beq_taken", {31'd0, bus.branch_taken}, 32'd1);
    check("beq_addr", {16'd0, bus.branch_addr}, 32'h0000_000C);
    check("beq_no_stall", {31'd0, bus.stall}, 32'd0);
    drive(r_type(5'd1, 5'd2, 5'd13) | {16'd0, 16'($urandom_range(0, 16'h07FF))}, 16'h11);
    tick();
    check("beq_after_taken", {31'd0, bus.branch_taken}, 32'd0);
    check("beq_in_ex", {31'd0, bus.ex_valid}, 32'd1);
    idle(1);
    check("beq_flushed_slot", {31'd0, bus.ex_valid}, 32'd0);
    idle(2);

    // BEQ source matches a writing ID/EX destination.
    t = i_type(6'h08, 5'd0, 5'd1, 16'h0005);
    drive(t, 16'h38);
    expect_ex(t, 16'h38, 32'h0, reg_model[1]);
    tick();
    t = i_type(6'h04, 5'd1, 5'd3, 16'h0003);
    drive(t, 16'h39);
    expect_ex(t, 16'h39, reg_model[1], reg_model[3]);
    tick();
    check("ex_branch_stall", {31'd0, bus.stall}, 32'd1);
    check("ex_branch_held", {31'd0, bus.branch_taken}, 32'd0);
    drive(NOP_INSTRUCTION, '0);
    tick();
    check("ex_branch_stall_clear", {31'd0, bus.stall}, 32'd0);
    check("beq_not_taken", {31'd0, bus.branch_taken}, 32'd0);
    idle(3);

    // BNE with rs matching a writing MEM destination.
    t = i_type(6'h05, 5'd1, 5'd3, 16'h0002);
    drive(t, 16'h40);
    expect_ex(t, 16'h40, reg_model[1], reg_model[3]);
    tick();
    bus.mem_we   = 1'b1;
    bus.mem_dest = 5'd1;
    drive(NOP_INSTRUCTION, '0);
    #1;
    check("mem_branch_stall", {31'd0, bus.stall}, 32'd1);
    check("mem_branch_held", {31'd0, bus.branch_taken}, 32'd0);
    tick();
    check("mem_branch_stall_hold", {31'd0, bus.stall}, 32'd1);
    check("mem_branch_bubble", {31'd0, bus.ex_valid}, 32'd0);
    bus.mem_we = 1'b0;
    #1;
    check("mem_branch_clear", {31'd0, bus.stall}, 32'd0);
    check("bne_taken", {31'd0, bus.branch_taken}, 32'd1);
    check("bne_addr", {16'd0, bus.branch_addr}, 32'h0000_0042);
    tick();
    check("bne_after_taken", {31'd0, bus.branch_taken}, 32'd0);
    idle(2);

    // J to 0x2A with the following instruction flushed.
    t = {6'h02, 26'h000_002A};
    drive(t, 16'h50);
    expect_ex(t, 16'h50, 32'h0, 32'h0);
    tick();
    check("j_is_jump", {31'd0, bus.is_jump}, 32'd1);
    check("j_addr", {16'd0, bus.jump_addr}, 32'h0000_002A);
    check("j_no_branch", {31'd0, bus.branch_taken}, 32'd0);
    drive(r_type(5'd2, 5'd3, 5'd14), 16'h51);
    tick();
    check("j_after", {31'd0, bus.is_jump}, 32'd0);
    check("j_in_ex", {26'd0, bus.ex_opcode}, 32'h02);
    idle(1);
    check("j_flushed_slot", {31'd0, bus.ex_valid}, 32'd0);
    idle(1);

    // r0 stays zero after a write attempt.
    wb_write(5'd0, $urandom_range(1, 32'hFFFF) | 32'h0001_0000);
    t = r_type(5'd0, 5'd0, 5'd15);
    drive(t, 16'h52);
    expect_ex(t, 16'h52, 32'h0, 32'h0);
    tick();
    idle(1);
    check("r0_reads_zero", bus.ex_rs_data, 32'h0);
    idle(2);

    // Asynchronous reset with a valid instruction in ID/EX.
    t = r_type(5'd1, 5'd2, 5'd3);
    drive(t, 16'h60);
    expect_ex(t, 16'h60, reg_model[1], reg_model[2]);
    tick();
    idle(1);
    check("pre_reset_valid", {31'd0, bus.ex_valid}, 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) reg_model[i] = '0;
    #1;
    check("mid_rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("mid_rst_ex_opcode", {26'd0, bus.ex_opcode}, 32'd0);
    check("mid_rst_ex_rs_data", bus.ex_rs_data, 32'd0);
    check("mid_rst_ex_imm", bus.ex_imm, 32'd0);
    check("mid_rst_ex_pc", {16'd0, bus.ex_pc}, 32'd0);
    check("mid_rst_ex_rd", {27'd0, bus.ex_rd}, 32'd0);
    check("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    rst = 1'b0;
    t = r_type(5'd1, 5'd2, 5'd3);
    drive(t, 16'h61);
    expect_ex(t, 16'h61, 32'h0, 32'h0);
    tick();
    idle(1);
    check("post_rst_regs_zero", bus.ex_rt_data, 32'h0);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
